// File: rtl/fault_inject_pkg.sv
// Shared types and constants for the single-fault injection sequencer.
package fault_inject_pkg;

  localparam int N_TGT_DEF = 6;

  localparam logic [2:0] TGT_A = 3'd0;
  localparam logic [2:0] TGT_B = 3'd1;
  localparam logic [2:0] TGT_C = 3'd2;
  localparam logic [2:0] TGT_D = 3'd3;
  localparam logic [2:0] TGT_E = 3'd4;
  localparam logic [2:0] TGT_F = 3'd5;

  localparam logic [1:0] MODE_SA0  = 2'd0;
  localparam logic [1:0] MODE_SA1  = 2'd1;
  localparam logic [1:0] MODE_FLIP = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    INJECT = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic logic desc_valid(input logic [2:0] target, input logic [1:0] mode,
                                      input int n_tgt);
    return (int'(target) < n_tgt) && (mode != MODE_RSVD);
  endfunction

endpackage

// File: rtl/fault_force_mux.sv
// Combinational forcing of one stimulus bit; everything else passes through untouched.
module fault_force_mux
  import fault_inject_pkg::*;
#(
  parameter int N_TGT = N_TGT_DEF
) (
  input  logic             en,
  input  logic [2:0]       target,
  input  logic [1:0]       mode,
  input  logic [N_TGT-1:0] func_in,
  output logic [N_TGT-1:0] func_out
);

  always_comb begin
    func_out = func_in;
    for (int i = 0; i < N_TGT; i++) begin
      if (en && (int'(target) == i)) begin
        case (mode)
          MODE_SA0:  func_out[i] = 1'b0;
          MODE_SA1:  func_out[i] = 1'b1;
          MODE_FLIP: func_out[i] = ~func_in[i];
          default:   func_out[i] = func_in[i];
        endcase
      end
    end
  end

endmodule

// File: rtl/fault_inject_sequencer.sv
// Runs one fault-injection campaign per accepted descriptor and counts output mismatches.
//
// state  | meaning
// IDLE   | ready for a descriptor
// DELAY  | counting down to the window start
// INJECT | fault forced, mismatches counted
// DONE   | one-cycle completion pulse
module fault_inject_sequencer
  import fault_inject_pkg::*;
#(
  parameter int N_TGT = N_TGT_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_target,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             abort,
  input  logic [N_TGT-1:0] func_in,
  output logic [N_TGT-1:0] func_out,
  input  logic [1:0]       y_obs,
  input  logic [1:0]       y_exp,
  output logic             inj_active,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             cfg_err,
  output logic [CNT_W-1:0] err_cnt
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q;
  logic [2:0]       tgt_q;
  logic [1:0]       mode_q;
  logic             accept, desc_ok, abort_hit;

  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q == DELAY) || (state_q == INJECT);
  assign done      = (state_q == DONE);
  assign accept    = cfg_valid && cfg_ready;
  assign desc_ok   = desc_valid(cfg_target, cfg_mode, N_TGT);
  assign abort_hit = abort && busy;

  // One shared down-counter: delay first, then reloaded with the window length.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!desc_ok) begin
            state_d = DONE;
          end else if (cfg_delay != '0) begin
            state_d = DELAY;
            cnt_d   = cfg_delay - CNT_W'(1);
          end else if (cfg_len == '0) begin
            state_d = DONE;
          end else begin
            state_d = INJECT;
            cnt_d   = cfg_len - CNT_W'(1);
          end
        end
      end
      DELAY: begin
        if (abort_hit) begin
          state_d = DONE;
        end else if (cnt_q == '0) begin
          if (len_q == '0) begin
            state_d = DONE;
          end else begin
            state_d = INJECT;
            cnt_d   = len_q - CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      INJECT: begin
        if (abort_hit || (cnt_q == '0)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      tgt_q      <= '0;
      mode_q     <= '0;
      inj_active <= 1'b0;
      aborted    <= 1'b0;
      cfg_err    <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inj_active <= (state_d == INJECT);
      if (accept) begin
        len_q   <= cfg_len;
        tgt_q   <= cfg_target;
        mode_q  <= cfg_mode;
        err_cnt <= '0;
        aborted <= 1'b0;
        cfg_err <= !desc_ok;
      end else begin
        if ((state_q == INJECT) && (y_obs != y_exp) && (err_cnt != {CNT_W{1'b1}})) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
        if (abort_hit) begin
          aborted <= 1'b1;
        end
      end
    end
  end

  // inj_active is cleared by reset, so the fault drops combinationally with rstn.
  fault_force_mux #(.N_TGT(N_TGT)) u_force (
    .en       (inj_active),
    .target   (tgt_q),
    .mode     (mode_q),
    .func_in  (func_in),
    .func_out (func_out)
  );

endmodule
